pixel_fb_writer: RTL and testbench

Consumer end of the rasteriser pixel stream. It accepts signed (x, y) pixel coordinates from the Processor draw core over a valid/ready handshake and buffers them in a small FIFO. Each pixel is translated from centred-origin coordinates to framebuffer row/column, clipped to the screen, and issued as a single-pixel write on a stallable framebuffer write port. The block also performs a full-screen clear on command, ordered after all pixels accepted earlier.

---
 rtl/gpu_pkg.sv | 58 +++++
 rtl/pixel_fifo.sv | 61 ++++++
 rtl/pixel_fb_writer.sv | 162 ++++++++++++++++
 tb/tb_pixel_fb_writer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: coordinate widths, draw opcodes, screen geometry,
// the pixel stream payload and the centred-origin -> framebuffer translation.
package gpu_pkg;

    localparam int unsigned X_W        = 9;
    localparam int unsigned Y_W        = 8;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_LINE   = 2'b01,
        OP_CIRCLE = 2'b10
    } draw_op_e;

    localparam int unsigned FB_W       = 256;
    localparam int unsigned FB_H       = 128;
    localparam int unsigned X_ORG      = 128;
    localparam int unsigned Y_ORG      = 64;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned COLOR_W    = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned COORD_W    = 11;
    localparam int unsigned COL_W      = $clog2(FB_W);
    localparam int unsigned ROW_W      = ADDR_W - COL_W;
    localparam int unsigned FB_PIXELS  = FB_W * FB_H;

    typedef struct packed {
        logic signed [X_W-1:0]     x;
        logic signed [Y_W-1:0]     y;
        logic        [COLOR_W-1:0] color;
    } pixel_t;

    typedef struct packed {
        logic              clip;
        logic [ADDR_W-1:0] addr;
    } fb_loc_t;

    // Centred origin with y upward -> row/col; FB_W is a power of two so
    // the address is a plain concatenation of row and column.
    function automatic fb_loc_t pix_translate(input logic signed [X_W-1:0] x,
                                              input logic signed [Y_W-1:0] y);
        logic signed [COORD_W-1:0] col;
        logic signed [COORD_W-1:0] row;
        fb_loc_t                   loc;
        col      = COORD_W'(x) + COORD_W'(X_ORG);
        row      = COORD_W'(Y_ORG) - COORD_W'(y);
        loc.clip = col[COORD_W-1] | row[COORD_W-1]
                 | (col[COORD_W-2:0] >= (COORD_W-1)'(FB_W))
                 | (row[COORD_W-2:0] >= (COORD_W-1)'(FB_H));
        loc.addr = {row[ROW_W-1:0], col[COL_W-1:0]};
        return loc;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with full/empty flags. A push into a full FIFO is
// accepted when a pop happens on the same edge.
// Ports: clk, rst_n (async active-low flush), push_i/wr_data_i write side,
//        pop_i/rd_data_c read side (head, combinational), full_c, empty_c.
module pixel_fifo
    import gpu_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  pixel_t wr_data_i,
    input  logic   pop_i,
    output pixel_t rd_data_c,
    output logic   full_c,
    output logic   empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    pixel_t      mem_q [DEPTH];
    logic        do_push_c;
    logic        do_pop_c;

    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW])
                    && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_c  = pop_i && !empty_c;
    assign do_push_c = push_i && (!full_c || do_pop_c);
    assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel stream -> framebuffer write port. Buffers incoming pixels, translates
// and clips them, and issues single-pixel writes; also runs an ordered
// full-screen clear.
// Ports: clk, reset (async active-low);
//        pix_valid/pix_ready/pix_x/pix_y/pix_color  pixel stream in;
//        clear_req/clear_color  clear command, busy while clear pending/active;
//        fb_we/fb_addr/fb_wdata/fb_wready  stallable framebuffer write port;
//        clip_cnt/wr_cnt  saturating statistics.
module pixel_fb_writer
    import gpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [X_W-1:0]    pix_x,
    input  logic signed [Y_W-1:0]    pix_y,
    input  logic        [COLOR_W-1:0] pix_color,
    input  logic                     clear_req,
    input  logic        [COLOR_W-1:0] clear_color,
    output logic                     busy,
    output logic                     fb_we,
    output logic        [ADDR_W-1:0] fb_addr,
    output logic        [COLOR_W-1:0] fb_wdata,
    input  logic                     fb_wready,
    output logic        [CNT_W-1:0]  clip_cnt,
    output logic        [CNT_W-1:0]  wr_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [COLOR_W-1:0] clr_color_q, clr_color_d;
    logic               we_q,        we_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [COLOR_W-1:0] wdata_q,     wdata_d;
    logic               busy_q,      busy_d;
    logic [CNT_W-1:0]   clip_cnt_q,  clip_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q,    wr_cnt_d;

    logic               push_c;
    logic               pop_c;
    logic               accept_c;
    pixel_t             push_data_c;
    pixel_t             head_c;
    logic               fifo_full_c;
    logic               fifo_empty_c;
    fb_loc_t            loc_c;

    assign pix_ready   = reset && !fifo_full_c && (state_q == S_IDLE);
    assign push_c      = pix_valid && pix_ready;
    assign push_data_c = '{x: pix_x, y: pix_y, color: pix_color};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push_i    (push_c),
        .wr_data_i (push_data_c),
        .pop_i     (pop_c),
        .rd_data_c (head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Translate/clip stage is combinational on the FIFO head.
    assign loc_c = pix_translate(head_c.x, head_c.y);

    // Next-state, pop control and output register reload
    always_comb begin
        state_d     = state_q;
        clr_color_d = clr_color_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        clip_cnt_d  = clip_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        pop_c       = 1'b0;
        accept_c    = we_q && fb_wready;

        case (state_q)
            S_IDLE, S_DRAIN: begin
                if (accept_c) begin
                    we_d     = 1'b0;
                    wr_cnt_d = sat_inc(wr_cnt_q);
                end
                // Clipped pixels drop out without waiting for the write port.
                if (!fifo_empty_c) begin
                    if (loc_c.clip) begin
                        pop_c      = 1'b1;
                        clip_cnt_d = sat_inc(clip_cnt_q);
                    end else if (!we_q || fb_wready) begin
                        pop_c   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = loc_c.addr;
                        wdata_d = head_c.color;
                    end
                end
                if ((state_q == S_IDLE) && clear_req) begin
                    state_d     = S_DRAIN;
                    clr_color_d = clear_color;
                end
                if ((state_q == S_DRAIN) && fifo_empty_c && !we_q) begin
                    state_d = S_CLEAR;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = clr_color_q;
                end
            end
            S_CLEAR: begin
                // The output address register doubles as the clear counter.
                if (accept_c) begin
                    if (addr_q == ADDR_W'(FB_PIXELS - 1)) begin
                        state_d = S_IDLE;
                        we_d    = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            clr_color_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            clip_cnt_q  <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_color_q <= clr_color_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            clip_cnt_q  <= clip_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign fb_we    = we_q;
    assign fb_addr  = addr_q;
    assign fb_wdata = wdata_q;
    assign busy     = busy_q;
    assign clip_cnt = clip_cnt_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Bench for pixel_fb_writer: table of single-pixel vectors, hand sequences
// for stall/clear/reset, and a randomized run against a queue-based model.
module tb_pixel_fb_writer;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_valid;
    logic              pix_ready;
    logic signed [8:0] pix_x;
    logic signed [7:0] pix_y;
    logic [0:0]        pix_color;
    logic              clear_req;
    logic [0:0]        clear_color;
    logic              busy;
    logic              fb_we;
    logic [14:0]       fb_addr;
    logic [0:0]        fb_wdata;
    logic              fb_wready;
    logic [15:0]       clip_cnt;
    logic [15:0]       wr_cnt;

    pixel_fb_writer dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_wready   (fb_wready),
        .clip_cnt    (clip_cnt),
        .wr_cnt      (wr_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit is_clear; int addr; int data; } wr_t;
    wr_t exp_q[$];
    int  m_wr    = 0;
    int  m_clip  = 0;
    bit  m_clearing = 0;

    task automatic model_accept(input int x, input int y, input int c);
        int col;
        int row;
        wr_t e;
        col = x + 128;
        row = 64 - y;
        if (col < 0 || col >= 256 || row < 0 || row >= 128) begin
            m_clip++;
        end else begin
            e.is_clear = 0;
            e.addr     = row * 256 + col;
            e.data     = c;
            exp_q.push_back(e);
            m_wr++;
        end
    endtask

    // Monitor: sampled mid-cycle; values seen here are what the next edge acts on.
    bit         prev_stall = 0;
    logic [14:0] prev_addr;
    logic [0:0]  prev_data;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 0;
        end else begin
            if (m_clearing) begin
                chk_eq("busy_during_clear", busy, 1);
                chk_eq("ready_during_clear", pix_ready, 0);
            end
            if (prev_stall) begin
                chk_eq("stall_hold_we", fb_we, 1);
                chk_eq("stall_hold_addr", fb_addr, prev_addr);
                chk_eq("stall_hold_data", fb_wdata, prev_data);
            end
            if (pix_valid && pix_ready)
                model_accept(int'(pix_x), int'(pix_y), int'(pix_color));
            if (clear_req && !m_clearing) begin
                m_clearing = 1;
                for (int a = 0; a < 32768; a++) begin
                    wr_t e;
                    e.is_clear = 1;
                    e.addr     = a;
                    e.data     = int'(clear_color);
                    exp_q.push_back(e);
                end
            end
            if (fb_we && fb_wready) begin
                chk_eq("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk_eq("write_addr", fb_addr, e.addr);
                    chk_eq("write_data", fb_wdata, e.data);
                    if (e.is_clear && exp_q.size() == 0) m_clearing = 0;
                end
            end
            prev_stall = fb_we && !fb_wready;
            prev_addr  = fb_addr;
            prev_data  = fb_wdata;
        end
    end

    // ---------------- helpers ----------------
    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send_pix(input int x, input int y, input int c);
        int n;
        n = 0;
        pix_x     = 9'(x);
        pix_y     = 8'(y);
        pix_color = 1'(c);
        pix_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_ready && n < 200);
        chk_eq("send_accept", pix_ready, 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk_eq(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    typedef struct { int x; int y; int c; bit clip; int addr; } vec_t;
    vec_t tbl[12];

    initial begin
        int tbl_clip;
        int tbl_wr;
        int xs[8];
        int ys[8];
        int idx;
        bit acc;
        bit found;

        reset       = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_color   = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        fb_wready   = 1'b1;

        // (x, y, colour, clipped, address = (64-y)*256 + (x+128))
        tbl[0]  = '{   5,    0, 1, 0, 16517};
        tbl[1]  = '{-129,    0, 1, 1,     0};
        tbl[2]  = '{   0,  -64, 0, 1,     0};
        tbl[3]  = '{ 127,   63, 1, 0,   511};
        tbl[4]  = '{-128,  -63, 1, 0, 32512};
        tbl[5]  = '{ 127,   64, 1, 0,   255};
        tbl[6]  = '{ 128,    0, 1, 1,     0};
        tbl[7]  = '{   0,   65, 1, 1,     0};
        tbl[8]  = '{-256, -128, 1, 1,     0};
        tbl[9]  = '{ 255,  127, 1, 1,     0};
        tbl[10] = '{   0,    0, 0, 0, 16512};
        tbl[11] = '{-128,   64, 1, 0,     0};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_pix_ready", pix_ready, 0);
        chk_eq("rst_fb_we", fb_we, 0);
        chk_eq("rst_fb_addr", fb_addr, 0);
        chk_eq("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("idle_pix_ready", pix_ready, 1);
        chk_eq("idle_fb_we", fb_we, 0);
        chk_eq("idle_busy", busy, 0);
        chk_eq("idle_clip_cnt", clip_cnt, 0);
        chk_eq("idle_wr_cnt", wr_cnt, 0);

        // ---- table: one pixel at a time, 2-cycle latency ----
        @(posedge clk);
        #1;
        tbl_clip = 0;
        tbl_wr   = 0;
        foreach (tbl[i]) begin
            send_pix(tbl[i].x, tbl[i].y, tbl[i].c);
            @(posedge clk);
            @(negedge clk);
            if (tbl[i].clip) tbl_clip++;
            chk_eq("tbl_fb_we", fb_we, !tbl[i].clip);
            if (!tbl[i].clip) begin
                chk_eq("tbl_fb_addr", fb_addr, tbl[i].addr);
                chk_eq("tbl_fb_wdata", fb_wdata, tbl[i].c);
            end
            chk_eq("tbl_clip_cnt", clip_cnt, tbl_clip);
            chk_eq("tbl_wr_cnt", wr_cnt, tbl_wr);
            if (!tbl[i].clip) tbl_wr++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_eq("tbl_wr_total", wr_cnt, tbl_wr);
        chk_eq("tbl_clip_total", clip_cnt, tbl_clip);

        // ---- stall with 8 back-to-back pixels ----
        @(posedge clk);
        #1;
        fb_wready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xs[i] = int'($urandom_range(0, 255)) - 128;
            ys[i] = int'($urandom_range(0, 127)) - 63;
        end
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            pix_valid = (idx < 8);
            if (idx < 8) begin
                pix_x     = 9'(xs[idx]);
                pix_y     = 8'(ys[idx]);
                pix_color = 1'(idx);
            end
            @(negedge clk);
            if (pix_valid && pix_ready) idx++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_eq("stall_accepted", idx, 5);
        chk_eq("stall_pix_ready", pix_ready, 0);
        chk_eq("stall_fb_we", fb_we, 1);
        @(posedge clk);
        #1;
        fb_wready = 1'b1;
        for (int cyc = 0; cyc < 50 && idx < 8; cyc++) begin
            pix_valid = 1'b1;
            pix_x     = 9'(xs[idx]);
            pix_y     = 8'(ys[idx]);
            pix_color = 1'(idx);
            @(negedge clk);
            if (pix_ready) idx++;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        chk_eq("stall_all_accepted", idx, 8);
        wait_drain("stall_drain");
        chk_eq("stall_wr_cnt", wr_cnt, m_wr);

        // ---- clear ordered after two queued pixels ----
        @(posedge clk);
        #1;
        fb_wready = 1'b0;
        send_pix(10, 10, 1);
        send_pix(-10, -10, 1);
        clear_req   = 1'b1;
        clear_color = 1'b0;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            fb_wready   = ($urandom_range(0, 7) != 0);
            clear_req   = (cyc == 1000);
            clear_color = 1'(cyc == 1000);
            @(posedge clk);
            #1;
            if (!m_clearing) begin
                found = 1;
                break;
            end
        end
        clear_req   = 1'b0;
        clear_color = 1'b0;
        fb_wready   = 1'b1;
        chk_eq("clear_done", found, 1);
        @(negedge clk);
        chk_eq("clear_busy_low", busy, 0);
        chk_eq("clear_ready_back", pix_ready, 1);
        chk_eq("clear_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk_eq("clear_no_restart", fb_we, 0);
        chk_eq("clear_wr_cnt_excl", wr_cnt, m_wr);

        // ---- reset in the middle of a clear ----
        @(posedge clk);
        #1;
        clear_req   = 1'b1;
        clear_color = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fb_we && fb_addr == 15'd100) begin
                found = 1;
                break;
            end
        end
        chk_eq("clear_reached_100", found, 1);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_clearing = 0;
        m_wr       = 0;
        m_clip     = 0;
        #1;
        chk_eq("abort_fb_we", fb_we, 0);
        chk_eq("abort_fb_addr", fb_addr, 0);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_pix_ready", pix_ready, 0);
        chk_eq("abort_wr_cnt", wr_cnt, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("post_abort_busy", busy, 0);
        chk_eq("post_abort_ready", pix_ready, 1);
        chk_eq("post_abort_fb_we", fb_we, 0);
        @(posedge clk);
        #1;
        send_pix(0, 0, 1);
        wait_drain("post_abort_drain");
        chk_eq("post_abort_wr_cnt", wr_cnt, 1);
        chk_eq("post_abort_clip_cnt", clip_cnt, 0);

        // ---- randomized traffic with random back-pressure ----
        @(posedge clk);
        #1;
        acc       = 0;
        pix_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pix_valid || acc) begin
                pix_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 1) == 1) begin
                    pix_x = 9'(int'($urandom_range(0, 259)) - 130);
                    pix_y = 8'(int'($urandom_range(0, 131)) - 66);
                end else begin
                    pix_x = 9'($urandom);
                    pix_y = 8'($urandom);
                end
                pix_color = 1'($urandom);
            end
            fb_wready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        fb_wready = 1'b1;
        wait_drain("rand_drain");
        @(negedge clk);
        chk_eq("rand_wr_cnt", wr_cnt, m_wr);
        chk_eq("rand_clip_cnt", clip_cnt, m_clip);
        chk_eq("rand_fb_we_idle", fb_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
